// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control symbols and the word-aligner state encoding.
package tmds_pkg;

  localparam logic [9:0] CTRL_SYM_00 = 10'h354;
  localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [9:0] CTRL_SYM_10 = 10'h154;
  localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

  typedef logic [1:0] state_t;

  localparam state_t HUNT    = 2'd0;
  localparam state_t CONFIRM = 2'd1;
  localparam state_t LOCKED  = 2'd2;

endpackage

// File: rtl/tmds_ctrl_match.sv
// Combinational TMDS control-symbol detector; reports a match and the {C1,C0} code it carries.
module tmds_ctrl_match
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_match,
  output logic [1:0] o_code
);

  always_comb begin
    o_match = 1'b1;
    o_code  = 2'b00;
    case (i_sym)
      CTRL_SYM_00: o_code = 2'b00;
      CTRL_SYM_01: o_code = 2'b01;
      CTRL_SYM_10: o_code = 2'b10;
      CTRL_SYM_11: o_code = 2'b11;
      default: begin
        o_match = 1'b0;
        o_code  = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/tmds_deserializer_1to10.sv
// 1:10 TMDS deserializer: shifts in serial bits, aligns on control symbols seen in blanking,
// and emits aligned 10-bit words with a valid strobe while locked.
module tmds_deserializer_1to10
  import tmds_pkg::*;
#(
  parameter int CTRL_LOCK = 4,
  parameter int MAX_GAP   = 4095
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bit,
  input  logic       i_bit_valid,
  input  logic       i_resync,
  output logic [9:0] o_data,
  output logic       o_data_valid,
  output logic       o_ctrl,
  output logic [1:0] o_ctrl_code,
  output logic       o_locked
);

  localparam int MW = $clog2(CTRL_LOCK + 1);
  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(CTRL_LOCK);
  localparam logic [GW-1:0] GAP_N  = GW'(MAX_GAP);

  logic [9:0]    r_shift;
  logic [3:0]    r_fill;
  logic [3:0]    r_phase;
  logic [MW-1:0] r_match_cnt;
  logic [GW-1:0] r_gap_cnt;
  state_t        r_state;
  logic [9:0]    r_data;
  logic          r_data_valid;
  logic          r_ctrl;
  logic [1:0]    r_ctrl_code;
  logic          r_locked;

  logic [9:0]    w_shift_next;
  logic          w_filled;
  logic          w_boundary;
  logic          w_is_ctrl;
  logic [1:0]    w_code;
  logic [MW-1:0] w_match_inc;
  logic [GW-1:0] w_gap_inc;
  state_t        w_state_next;
  logic [3:0]    w_phase_next;
  logic [MW-1:0] w_match_next;
  logic [GW-1:0] w_gap_next;
  logic          w_emit;

  // Matching looks at the register as it will be after this cycle's bit lands.
  assign w_shift_next = {i_bit, r_shift[9:1]};
  assign w_filled     = (r_fill >= 4'd9);
  assign w_boundary   = (r_phase == 4'd9);
  assign w_match_inc  = r_match_cnt + MW'(1);
  assign w_gap_inc    = r_gap_cnt + GW'(1);

  tmds_ctrl_match u_ctrl_match (
    .i_sym   (w_shift_next),
    .o_match (w_is_ctrl),
    .o_code  (w_code)
  );

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_match_next = r_match_cnt;
    w_gap_next   = r_gap_cnt;
    w_emit       = 1'b0;
    if (i_resync) begin
      w_state_next = HUNT;
      w_phase_next = 4'd0;
      w_match_next = '0;
      w_gap_next   = '0;
    end else if (i_bit_valid) begin
      w_phase_next = w_boundary ? 4'd0 : r_phase + 4'd1;
      case (r_state)
        HUNT: begin
          if (w_filled && w_is_ctrl) begin
            w_phase_next = 4'd0;
            w_match_next = MW'(1);
            w_gap_next   = '0;
            w_state_next = (CTRL_LOCK == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (w_boundary) begin
            if (w_is_ctrl) begin
              w_match_next = w_match_inc;
              if (w_match_inc == LOCK_N) w_state_next = LOCKED;
            end else begin
              w_match_next = '0;
              w_state_next = HUNT;
            end
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            w_emit = 1'b1;
            if (w_is_ctrl) begin
              w_gap_next = '0;
            end else if (w_gap_inc == GAP_N) begin
              // Too long without blanking: this word still goes out, then re-hunt.
              w_gap_next   = '0;
              w_match_next = '0;
              w_state_next = HUNT;
            end else begin
              w_gap_next = w_gap_inc;
            end
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift      <= '0;
      r_fill       <= '0;
      r_phase      <= '0;
      r_match_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_state      <= HUNT;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_ctrl       <= 1'b0;
      r_ctrl_code  <= 2'b00;
      r_locked     <= 1'b0;
    end else begin
      if (i_bit_valid) begin
        r_shift <= w_shift_next;
        if (r_fill != 4'd10) r_fill <= r_fill + 4'd1;
      end
      if (w_emit) begin
        r_data      <= w_shift_next;
        r_ctrl      <= w_is_ctrl;
        r_ctrl_code <= w_code;
      end
      r_data_valid <= w_emit;
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_match_cnt  <= w_match_next;
      r_gap_cnt    <= w_gap_next;
      r_locked     <= (w_state_next == LOCKED);
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_ctrl       = r_ctrl;
  assign o_ctrl_code  = r_ctrl_code;
  assign o_locked     = r_locked;

endmodule

// File: tb/tb_tmds_deserializer_1to10.sv
// Directed bench for tmds_deserializer_1to10 (CTRL_LOCK=4, MAX_GAP=8): fill, lock, gapped valid,
// confirm failure, gap timeout, resync collision and asynchronous reset mid-word.
module tb_tmds_deserializer_1to10;

  logic       clk;
  logic       i_rst_n;
  logic       i_bit;
  logic       i_bit_valid;
  logic       i_resync;
  logic [9:0] o_data;
  logic       o_data_valid;
  logic       o_ctrl;
  logic [1:0] o_ctrl_code;
  logic       o_locked;

  int         n_checks;
  int         n_fail;
  int         pulses;
  int         bit_idx;
  int         last_pulse_bit;
  logic [9:0] last_data;
  logic       last_ctrl;
  logic [1:0] last_code;
  logic [9:0] sym;

  tmds_deserializer_1to10 #(.CTRL_LOCK(4), .MAX_GAP(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_bit        (i_bit),
    .i_bit_valid  (i_bit_valid),
    .i_resync     (i_resync),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_ctrl       (o_ctrl),
    .o_ctrl_code  (o_ctrl_code),
    .o_locked     (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic send_bit(input logic b, input logic v, input logic rs);
    i_bit       = b;
    i_bit_valid = v;
    i_resync    = rs;
    @(posedge clk);
    #1;
    i_bit_valid = 1'b0;
    i_resync    = 1'b0;
    bit_idx++;
    if (o_data_valid === 1'b1) begin
      pulses++;
      last_pulse_bit = bit_idx;
      last_data      = o_data;
      last_ctrl      = o_ctrl;
      last_code      = o_ctrl_code;
    end
  endtask

  task automatic start_window();
    pulses         = 0;
    bit_idx        = 0;
    last_pulse_bit = 0;
  endtask

  task automatic send_word(input logic [9:0] w, input logic rs_last);
    start_window();
    for (int i = 0; i < 10; i++) send_bit(w[i], 1'b1, rs_last && (i == 9));
  endtask

  task automatic chk_emit(input string tag, input logic [9:0] d, input logic c, input logic [1:0] code);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_pulse_at"}, last_pulse_bit, bit_idx);
    chk({tag, "_data"}, last_data, d);
    chk({tag, "_ctrl"}, last_ctrl, c);
    chk({tag, "_code"}, last_code, code);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    i_rst_n     = 1'b0;
    i_bit       = 1'b0;
    i_bit_valid = 1'b0;
    i_resync    = 1'b0;
    start_window();

    // Reset held for 3 cycles: every output at 0.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", o_data, 10'h000);
    chk("rst_valid", o_data_valid, 1'b0);
    chk("rst_ctrl", o_ctrl, 1'b0);
    chk("rst_code", o_ctrl_code, 2'b00);
    chk("rst_locked", o_locked, 1'b0);
    i_rst_n = 1'b1;

    // Nine bits b1..b9 of 0x354 leave 0x354 in the register, but fill is not complete.
    sym = 10'h354;
    start_window();
    for (int i = 1; i < 10; i++) send_bit(sym[i], 1'b1, 1'b0);
    chk("fill_pulses", pulses, 0);
    chk("fill_locked", o_locked, 1'b0);
    chk("fill_data", o_data, 10'h000);
    chk("fill_ctrl", o_ctrl, 1'b0);

    // Three filler bits, then 6 x 0x354: locks after the 4th, emits the 5th and 6th.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) send_word(10'h354, 1'b0);
    chk("lock_w3_locked", o_locked, 1'b0);
    chk("lock_w3_pulses", pulses, 0);
    send_word(10'h354, 1'b0);
    chk("lock_w4_locked", o_locked, 1'b1);
    chk("lock_w4_pulses", pulses, 0);
    send_word(10'h354, 1'b0);
    chk_emit("lock_w5", 10'h354, 1'b1, 2'b00);
    send_word(10'h354, 1'b0);
    chk_emit("lock_w6", 10'h354, 1'b1, 2'b00);

    // Code 01 words, then 0x1F0 with valid on every other cycle.
    send_word(10'h0AB, 1'b0);
    chk_emit("ab_w1", 10'h0AB, 1'b1, 2'b01);
    send_word(10'h0AB, 1'b0);
    chk_emit("ab_w2", 10'h0AB, 1'b1, 2'b01);
    sym = 10'h1F0;
    start_window();
    for (int i = 0; i < 10; i++) begin
      send_bit(sym[i], 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
    end
    chk("gapped_pulses", pulses, 1);
    chk("gapped_pulse_at", last_pulse_bit, 19);
    chk("gapped_data", last_data, 10'h1F0);
    chk("gapped_ctrl", last_ctrl, 1'b0);
    chk("gapped_code", last_code, 2'b00);
    chk("gapped_hold_data", o_data, 10'h1F0);
    chk("gapped_hold_valid", o_data_valid, 1'b0);
    send_word(10'h354, 1'b0);
    chk_emit("gapped_clr", 10'h354, 1'b1, 2'b00);

    // 7 data words then a control word keep lock.
    for (int k = 0; k < 7; k++) begin
      send_word(10'h1F0, 1'b0);
      chk_emit("gap7_data", 10'h1F0, 1'b0, 2'b00);
      chk("gap7_locked", o_locked, 1'b1);
    end
    send_word(10'h354, 1'b0);
    chk_emit("gap7_ctrl", 10'h354, 1'b1, 2'b00);
    chk("gap7_ctrl_locked", o_locked, 1'b1);

    // 8 data words: all emitted, lock drops right after the 8th.
    for (int k = 0; k < 8; k++) begin
      send_word(10'h1F0, 1'b0);
      chk_emit("gap8_data", 10'h1F0, 1'b0, 2'b00);
      chk("gap8_locked", o_locked, (k < 7) ? 1'b1 : 1'b0);
    end
    send_word(10'h1F0, 1'b0);
    chk("hunt_no_pulse", pulses, 0);

    // Two 0x2AB then a data word: confirm fails, then 4 x 0x154 locks with code 10.
    send_word(10'h2AB, 1'b0);
    send_word(10'h2AB, 1'b0);
    chk("cf_2ab_locked", o_locked, 1'b0);
    send_word(10'h1F0, 1'b0);
    chk("cf_data_locked", o_locked, 1'b0);
    chk("cf_data_pulses", pulses, 0);
    for (int k = 1; k <= 3; k++) send_word(10'h154, 1'b0);
    chk("cf_154_w3_locked", o_locked, 1'b0);
    send_word(10'h154, 1'b0);
    chk("cf_154_w4_locked", o_locked, 1'b1);
    send_word(10'h154, 1'b0);
    chk_emit("cf_154_w5", 10'h154, 1'b1, 2'b10);

    // Resync on a locked word boundary: no strobe, lock drops, relock after 4 more symbols.
    send_word(10'h154, 1'b1);
    chk("rs_pulses", pulses, 0);
    chk("rs_locked", o_locked, 1'b0);
    for (int k = 1; k <= 3; k++) send_word(10'h154, 1'b0);
    chk("rs_w3_locked", o_locked, 1'b0);
    chk("rs_w3_pulses", pulses, 0);
    send_word(10'h154, 1'b0);
    chk("rs_w4_locked", o_locked, 1'b1);
    send_word(10'h154, 1'b0);
    chk_emit("rs_w5", 10'h154, 1'b1, 2'b10);

    // Asynchronous reset mid-word while locked: outputs clear before the next edge.
    sym = 10'h354;
    start_window();
    for (int i = 0; i < 4; i++) send_bit(sym[i], 1'b1, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_locked", o_locked, 1'b0);
    chk("arst_data", o_data, 10'h000);
    chk("arst_code", o_ctrl_code, 2'b00);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    send_word(10'h354, 1'b0);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_locked", o_locked, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_deserializer_1to10.md
Name: tmds_deserializer_1to10

Overview:
- Receive-side counterpart of the 10:1 TMDS serializer: rebuilds 10-bit TMDS symbols from a one-bit-per-valid-cycle serial stream.
- Finds word alignment by hunting for TMDS control symbols, which appear during blanking.
- Reports lock and emits aligned words with a valid strobe.
- Sits behind a bit-recovery/oversampling front end; feeds a downstream TMDS decoder.

Parameters:
- CTRL_LOCK, 4: consecutive aligned control symbols required to declare lock (1..15).
- MAX_GAP, 4095: consecutive non-control words tolerated while locked before lock is dropped (≥2).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_bit  in  1  serial data bit; bit 0 of each symbol is sent first
- i_bit_valid  in  1  i_bit is valid this cycle
- i_resync  in  1  one-cycle pulse: discard alignment, return to HUNT
- o_data  out  10  aligned symbol; bit 0 = first received bit
- o_data_valid  out  1  one-cycle strobe per aligned word, only while locked
- o_ctrl  out  1  o_data is a control symbol; qualified by o_data_valid
- o_ctrl_code  out  2  {C1,C0} of control symbol: 0x354→00, 0x0AB→01, 0x154→10, 0x2AB→11; 00 when o_ctrl=0
- o_locked  out  1  alignment locked

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - All outputs 0.
  - Shift register 0, fill count 0, phase 0, match count 0, gap count 0, state HUNT.
- Shift register:
  - On each i_bit_valid, i_bit enters bit 9 and the register shifts right.
  - After 10 valid bits, bit 0 holds the oldest bit.
  - Cycles with i_bit_valid=0 change nothing; outputs hold, o_data_valid=0.
- Fill: matches are ignored until 10 valid bits have been shifted since reset. The fill count saturates and is not cleared by i_resync.
- Match: the post-shift register value equals one of the four control symbols.
- HUNT:
  - Evaluates every valid bit.
  - On a match: phase←0, match count←1, go to CONFIRM. If CTRL_LOCK=1, go directly to LOCKED.
- Phase counter: 0..9. It advances on each valid bit and wraps 9→0. A word boundary is the valid bit that takes phase from 9 to 0.
- CONFIRM, at each word boundary:
  - Match: match count+1. On reaching CTRL_LOCK, go to LOCKED.
  - Non-match: go to HUNT, match count←0.
- LOCKED, at each word boundary:
  - Register the word to o_data. Pulse o_data_valid the next cycle (latency: 1 cycle after the completing valid bit). Drive o_ctrl and o_ctrl_code in the same cycle.
  - Control word: gap count←0.
  - Otherwise: gap count+1. When it reaches MAX_GAP, that word is still emitted, then state→HUNT.
- o_locked: registered. Goes 1 the cycle after entry to LOCKED; goes 0 the cycle after leaving LOCKED.
- No o_data_valid is produced outside LOCKED. The word that completes lock is not emitted; the first emitted word is the next one.
- i_resync:
  - Forces HUNT and clears phase, match count and gap count.
  - Takes priority over any same-cycle match or boundary event.
  - The same-cycle bit is still shifted in but is not evaluated for a match.
  - o_locked=0 the next cycle, and no o_data_valid is issued for that cycle's bit.
- Reset mid-word or while locked: immediate return to reset state; no partial word is emitted.
- Counter widths:
  - Match count: $clog2(CTRL_LOCK+1).
  - Gap count: $clog2(MAX_GAP+1); saturating logic is unnecessary because it resets at MAX_GAP.

Decomposition:
- Package tmds_pkg:
  - CTRL_SYM_00/01/10/11 constants (0x354, 0x0AB, 0x154, 0x2AB).
  - 2-bit state typedef/localparams HUNT=0, CONFIRM=1, LOCKED=2.
- Sub-module tmds_ctrl_match (combinational): 10-bit in → match flag plus 2-bit code. Instantiated once on the post-shift register value; shareable with the future TMDS decoder.

Test Plan:
- Reset and fill: hold i_rst_n low 3 cycles, then send 9 bits forming a 0x354 suffix → o_locked=0, no o_data_valid, all outputs 0.
- Lock: 3 random bits, then 6×0x354 LSB-first, valid every cycle → o_locked rises 1 cycle after the 4th symbol's last bit. Two words 0x354 follow with o_ctrl=1, o_ctrl_code=00, one valid pulse every 10 cycles.
- Gapped valid and data: lock on 0x0AB (code 01), then data 0x1F0 with i_bit_valid toggling 1/0 → o_data=0x1F0, o_ctrl=0, o_data_valid 1 cycle after every 10th valid bit.
- Confirm failure: 2×0x2AB then 0x1F0 → stays HUNT, o_locked=0. A following 4×0x154 locks with code 10.
- Gap timeout (MAX_GAP=8): lock, then 8 data words → all 8 emitted, o_locked falls the cycle after the 8th. With 7 data words then 0x354, lock is retained.
- Resync collision: assert i_resync on the same cycle as a locked word boundary → no o_data_valid, o_locked=0 next cycle. Relock after 4 more control symbols.
